// File: rtl/cbus_rr_arbiter_pkg.sv
// cbus_rr_arbiter_pkg: CBus request/response types, arbiter state and index-width helper
package cbus_rr_arbiter_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    function automatic int arb_idx_w(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/cbus_rr_arbiter_if.sv
// cbus_rr_arbiter_if: requester-side and memory-side CBus signals of the arbiter
interface cbus_rr_arbiter_if
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2
);
    cbus_req_t  ireqs  [NUM_INPUTS];
    cbus_resp_t iresps [NUM_INPUTS];
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    modport slave  (input ireqs, oresp, output iresps, oreq);
    modport master (output ireqs, oresp, input iresps, oreq);
endinterface

// File: rtl/cbus_rr_arbiter_picker.sv
// rr_priority_picker: index of the first set request bit at or after base, wrapping around
module rr_priority_picker #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req_vec,
    input  logic [W-1:0] base,
    output logic         any,
    output logic [W-1:0] idx
);
    logic [N-1:0] rot;

    always_comb begin
        rot = N'({req_vec, req_vec} >> base);
        any = |req_vec;
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (rot[k]) idx = W'((int'(base) + k) % N);
    end
endmodule

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: holds one CBus requester's grant for a whole burst until ready && last.
// CBUS_ARB_RR_EN selects round-robin; undefined gives fixed priority (lowest index wins).
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2
) (
    input logic              clk,
    input logic              resetn,
    cbus_rr_arbiter_if.slave bus
);
    localparam int IDX_W = arb_idx_w(NUM_INPUTS);

    arb_state_t            state;
    logic [IDX_W-1:0]      sel;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      win;
    logic [NUM_INPUTS-1:0] req_vec;
    logic                  any;

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NUM_INPUTS; i++) req_vec[i] = bus.ireqs[i].valid;
    end

    rr_priority_picker #(.N(NUM_INPUTS), .W(IDX_W)) u_picker (
        .req_vec (req_vec),
        .base    (rr_ptr),
        .any     (any),
        .idx     (win)
    );

`ifndef CBUS_ARB_RR_EN
    assign rr_ptr = '0;
`endif

    // The picker only sees registered state and request valids, never oresp.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            sel   <= '0;
`ifdef CBUS_ARB_RR_EN
            rr_ptr <= '0;
`endif
        end else if (state == IDLE) begin
            if (any) begin
                state <= BUSY;
                sel   <= win;
            end
        end else if (bus.oresp.ready && bus.oresp.last) begin
            state <= IDLE;
`ifdef CBUS_ARB_RR_EN
            rr_ptr <= (sel == IDX_W'(NUM_INPUTS - 1)) ? '0 : sel + 1'b1;
`endif
        end
    end

    always_comb begin
        bus.oreq = '0;
        for (int i = 0; i < NUM_INPUTS; i++) bus.iresps[i] = '0;
        if (state == BUSY) begin
            bus.oreq        = bus.ireqs[sel];
            bus.iresps[sel] = bus.oresp;
        end
    end

    // Owner must keep valid for its whole burst; a drop is forwarded but flagged here.
    a_hold_valid: assert property (@(posedge clk) disable iff (!resetn)
        (state == BUSY) |-> bus.ireqs[sel].valid);
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: randomized requesters and memory slave scored against a cycle-level arbitration model
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    localparam int N = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    cbus_rr_arbiter_if #(.NUM_INPUTS(N)) bus ();
    cbus_rr_arbiter #(.NUM_INPUTS(N)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    int n_checks = 0;
    int n_fail = 0;
    int p_req = 30;
    int p_ready = 70;
    bit stop_req = 1'b0;
    bit done [N];
    int beat = 0;
    int grants = 0;
    bit hit = 1'b0;

    cbus_resp_t beat_q [$];
    int         grant_q [$];

    bit m_busy = 1'b0;
    int m_owner = 0;
    int m_last = N - 1;
    bit prev_ovalid = 1'b0;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic cbus_req_t new_req(input int i);
        cbus_req_t r;
        r.valid    = 1'b1;
        r.is_write = 1'($urandom);
        r.size     = 3'd2;
        r.addr     = {4'(i), 28'($urandom)};
        r.strobe   = 4'($urandom);
        r.data     = $urandom;
        r.len      = 4'($urandom_range(3));
        return r;
    endfunction

    // Winner from the pending set: round-robin resumes after the previous owner, else lowest index.
    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
`ifdef CBUS_ARB_RR_EN
            int c = (m_last + k) % N;
`else
            int c = k - 1;
`endif
            if (bus.ireqs[c].valid) return c;
        end
        return -1;
    endfunction

    // Requesters and memory slave
    initial begin
        for (int i = 0; i < N; i++) bus.ireqs[i] = '0;
        bus.oresp = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (!resetn || done[i]) bus.ireqs[i] = '0;
                if (resetn && !stop_req && !bus.ireqs[i].valid && $urandom_range(99) < p_req)
                    bus.ireqs[i] = new_req(i);
            end
            #1;
            if (!resetn || !bus.oreq.valid) begin
                bus.oresp = '0;
                if (!resetn) beat = 0;
            end else begin
                bus.oresp.ready = ($urandom_range(99) < p_ready);
                bus.oresp.last  = bus.oresp.ready && (beat == int'(bus.oreq.len));
                bus.oresp.data  = bus.oresp.ready ? {bus.oreq.addr[23:0], beat[7:0]} : $urandom;
                if (bus.oresp.ready) begin
                    beat_q.push_back(bus.oresp);
                    beat = bus.oresp.last ? 0 : beat + 1;
                end
            end
        end
    end

    // Monitor, then advance the reference model with this cycle's inputs
    always @(negedge clk) begin
        cbus_req_t  exp_req;
        cbus_resp_t exp_resp;
        cbus_resp_t e;
        int         g;
        if (bus.oreq.valid && !prev_ovalid) begin
            g = (grant_q.size() != 0) ? grant_q.pop_front() : -1;
            chk(int'(bus.oreq.addr[31:28]) == g, "grant_order", 128'(bus.oreq.addr[31:28]), 128'(g));
            grants++;
        end
        exp_req = '0;
        if (m_busy) exp_req = bus.ireqs[m_owner];
        chk(bus.oreq == exp_req, "oreq", 128'(bus.oreq), 128'(exp_req));
        for (int j = 0; j < N; j++) begin
            exp_resp = '0;
            if (m_busy && j == m_owner) exp_resp = bus.oresp;
            chk(bus.iresps[j] == exp_resp, "iresp", 128'(bus.iresps[j]), 128'(exp_resp));
            if (bus.iresps[j].ready) begin
                e = (beat_q.size() != 0) ? beat_q.pop_front() : '0;
                chk(bus.iresps[j] == e && j == m_owner, "beat", 128'(bus.iresps[j]), 128'(e));
            end
            done[j] = bus.iresps[j].ready && bus.iresps[j].last;
        end
        prev_ovalid = bus.oreq.valid;
        if (!resetn) begin
            m_busy = 1'b0;
            m_last = N - 1;
        end else if (!m_busy) begin
            g = pick();
            if (g >= 0) begin
                m_busy  = 1'b1;
                m_owner = g;
                grant_q.push_back(g);
            end
        end else if (bus.oresp.ready && bus.oresp.last) begin
            m_busy = 1'b0;
            m_last = m_owner;
        end
    end

    task automatic run_phase(input int pr, input int py, input int cycles);
        p_req   = pr;
        p_ready = py;
        repeat (cycles) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        run_phase(30, 70, 400);
        run_phase(100, 100, 300);
        run_phase(60, 30, 400);
        p_req   = 100;
        p_ready = 50;
        for (int k = 0; k < 500 && !hit; k++) begin
            @(posedge clk);
            #1;
            if (bus.oreq.valid && beat == 2) hit = 1'b1;
        end
        chk(hit, "reset_wait", 128'(hit), 128'(1));
        resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        run_phase(40, 60, 200);
        stop_req = 1'b1;
        run_phase(0, 100, 60);
        @(negedge clk);
        #1;
        chk(beat_q.size() == 0, "beats_drained", 128'(beat_q.size()), 128'(0));
        chk(grant_q.size() == 0, "grants_drained", 128'(grant_q.size()), 128'(0));
        chk(grants >= 50, "grant_count", 128'(grants), 128'(50));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
